// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit add slice reused over NIBBLES cycles, LSB nibble first.
// Optional macro NIBBLE_SERIAL_SUB_EN adds a 'sub' input that turns the operation into a - b.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic [1:0]             dbg_state
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  // Handshake: start is accepted only when the FSM is IDLE or DONE (never while busy);
  // done is a one-cycle pulse in the cycle after the last nibble, with sum/cout valid from then on.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_psum;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic            w_accept;
  logic            w_last;
  logic            w_init_carry;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [4:0]      w_s4;
  logic [W-1:0]    w_psum_next;
  logic [IW+1:0]   w_bit_idx;

`ifdef NIBBLE_SERIAL_SUB_EN
  logic            r_sub;
  // Subtraction as a + ~b + 1: invert B per nibble and seed the carry with 1.
  assign w_init_carry = sub;
  assign w_b_nib      = r_sub ? ~r_b[w_bit_idx +: 4] : r_b[w_bit_idx +: 4];
`else
  assign w_init_carry = 1'b0;
  assign w_b_nib      = r_b[w_bit_idx +: 4];
`endif

  assign w_bit_idx = {r_idx, 2'b00};
  assign w_a_nib   = r_a[w_bit_idx +: 4];
  assign w_s4      = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
  assign w_last    = (r_idx == IW'(NIBBLES - 1));
  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_psum_next = r_psum;
    w_psum_next[w_bit_idx +: 4] = w_s4[3:0];
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_psum  <= '0;
        r_carry <= w_init_carry;
        r_idx   <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
        r_sub   <= sub;
`endif
      end else if (r_state == S_RUN) begin
        r_psum  <= w_psum_next;
        r_carry <= w_s4[4];
        // Hold idx on the last nibble so it never wraps inside an operation.
        if (!w_last) r_idx <= r_idx + 1'b1;
        if (w_last) begin
          r_sum  <= w_psum_next;
          r_cout <= w_s4[4];
        end
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): scoreboard of expected {cout,sum}
// pushed on each accepted start and popped whenever done pulses.
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic         sub;
`endif

  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check_eq("result", 32'({cout, sum}), 32'(e));
      end
    end
  end

  // Called at a negedge; start is seen by the next posedge, returns at the following negedge.
  task automatic drive_start(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic s_v);
    logic [W:0] e;
    if (s_v) e = {1'b0, a_v} + {1'b0, ~b_v} + 17'd1;
    else     e = {1'b0, a_v} + {1'b0, b_v};
    exp_q.push_back(e);
    start = 1'b1;
    a     = a_v;
    b     = b_v;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub   = s_v;
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic s_v);
    int cyc;
    drive_start(a_v, b_v, s_v);
    check_eq("op_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    check_eq("op_latency", 32'(cyc), 32'(NIB));
  endtask

  initial begin
    int cyc;
    int cnt0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_sum",   32'(sum),  32'd0);
    check_eq("rst_cout",  32'(cout), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add with explicit per-cycle timing.
    drive_start(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < NIB; i++) begin
      check_eq("t1_busy", 32'(busy), 32'd1);
      check_eq("t1_done_lo", 32'(done), 32'd0);
      @(negedge clk);
    end
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_busy_lo", 32'(busy), 32'd0);
    check_eq("t1_state_done", 32'(dbg_state), 32'd2);
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(done), 32'd0);
    check_eq("t1_state_idle", 32'(dbg_state), 32'd0);

    // Full carry ripple.
    do_op(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    do_op(16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge clk);

    // Start during RUN is ignored; old result holds throughout RUN.
    drive_start(16'h0F0F, 16'h0101, 1'b0);
    cnt0 = done_cnt;
    check_eq("t3_hold0", 32'({cout, sum}), 32'h1FFFE);
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    check_eq("t3_hold1", 32'({cout, sum}), 32'h1FFFE);
    check_eq("t3_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    repeat (4) @(negedge clk);
    check_eq("t3_one_done", 32'(done_cnt - cnt0), 32'd1);

    // Reset in the second RUN cycle.
    drive_start(16'h1111, 16'h2222, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_eq("t4_busy",  32'(busy), 32'd0);
    check_eq("t4_done",  32'(done), 32'd0);
    check_eq("t4_sum",   32'(sum),  32'd0);
    check_eq("t4_cout",  32'(cout), 32'd0);
    check_eq("t4_state", 32'(dbg_state), 32'd0);
    do_op(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);

    // Back-to-back: start held in the DONE cycle.
    do_op(16'h1000, 16'h0001, 1'b0);
    drive_start(16'h8000, 16'h8000, 1'b0);
    check_eq("t5_busy", 32'(busy), 32'd1);
    check_eq("t5_state_run", 32'(dbg_state), 32'd1);
    wait_done(cyc);
    check_eq("t5_gap", 32'(cyc + 1), 32'(NIB + 1));
    @(negedge clk);

    // Random operands.
    repeat (8) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      do_op(ra, rb, 1'b0);
      @(negedge clk);
    end

`ifdef NIBBLE_SERIAL_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1);
    @(negedge clk);
    do_op(16'h0007, 16'h0005, 1'b1);
    @(negedge clk);
    repeat (4) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      do_op(ra, rb, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
`endif

    repeat (3) @(negedge clk);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-word adder that reuses one 4-bit add slice over several cycles.
- Adds two NIBBLES×4-bit operands, one nibble per clock, least significant nibble first.
- The carry out of each nibble is registered and becomes the carry in of the next.
- Sits between the operand source and the result consumer, where a full-width single-cycle adder is not wanted.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 2..16

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new addition; sampled only in IDLE or DONE
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
busy  output  1  high while in RUN
done  output  1  single-cycle pulse when result is valid
sum  output  W  result register, updated only at completion
cout  output  1  carry out of the most significant nibble, updated with sum

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand, partial-sum, carry and nibble-counter registers are cleared.
  - Reset overrides everything, including start and a mid-operation RUN; the partial result is discarded.
- State machine: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a, b; clear carry register and counter idx; go to RUN. start=0 → stay.
  - RUN, each cycle:
    - s4 = A[idx] + B[idx] + carry (5-bit result, natural width, no truncation before the carry split).
    - s4[3:0] is written into partial-sum nibble idx; carry <= s4[4]; idx <= idx+1.
    - When idx = NIBBLES-1: sum <= full partial sum including the final nibble; cout <= final carry; go to DONE.
  - DONE: done=1 for exactly this one cycle.
    - start=1 → capture new operands and go to RUN (back-to-back accepted).
    - Otherwise go to IDLE.
- busy = (state==RUN); done = (state==DONE); both are registered-state decodes with no combinational path from inputs.
- Latency:
  - start accepted at edge k → busy high for cycles k+1..k+NIBBLES → done high in cycle k+NIBBLES+1.
  - sum/cout are valid from that cycle and hold until the next completion.
- start while busy: ignored, no effect on the operation in flight. a/b changes during RUN: no effect.
- sum/cout keep the previous result throughout RUN; no partial values are visible.
- idx is wide enough for NIBBLES-1. It never wraps during an operation and is reset to 0 on each accepted start.
- Carry chain across nibbles is exact: the result equals (a+b) mod 2^W, with cout = bit W of the true sum.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands on accepted start.
  - sub=1: B is replaced by ~B and the initial carry is 1, so the block computes a-b mod 2^W.
  - cout=1 means no borrow (a>=b unsigned); cout=0 means borrow.
  - sub=0: behaviour identical to the undefined build.
- Undefined: no sub port; addition only; initial carry is always 0.

Test Plan:
- NIBBLES=4, rst then start with a=0x1234, b=0x4321 → busy high 4 cycles, done pulse in 5th cycle after start edge, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001 → carry ripples through all nibbles: sum=0x0000, cout=1. Then a=0xFFFF, b=0xFFFF → sum=0xFFFE, cout=1.
- Start a=0x0F0F, b=0x0101; pulse start with other operands during RUN → ignored; sum=0x1010, cout=0, exactly one done pulse. Verify sum holds the old value during RUN.
- Assert rst during the 2nd RUN cycle → next cycle busy=0, done=0, sum=0, cout=0, state IDLE. A new start afterwards completes normally.
- Hold start=1 in the DONE cycle with a=0x8000, b=0x8000 → no IDLE cycle, immediate RUN, sum=0x0000, cout=1, second done 5 cycles after the first.
- With NIBBLE_SERIAL_SUB_EN, sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0. With a=0x0007, b=0x0005 → sum=0x0002, cout=1.
